// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline. It keeps a shadow scoreboard of the E/M/W
// stages and a mult/div busy counter.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic       D_rs_used,
  input  logic       D_rt_used,
  input  logic       D_Tuse_rs,
  input  logic       D_Tuse_rt,
  input  logic       D_we,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_Tnew,
  input  logic       D_is_md,
  input  logic       D_is_div,
  input  logic       D_uses_hilo,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_E,
  output logic [1:0] fwd_D_rs,
  output logic [1:0] fwd_D_rt,
  output logic [1:0] fwd_E_rs,
  output logic [1:0] fwd_E_rt,
  output logic       md_busy
);

  localparam int unsigned CntMax = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] dst;
    logic [1:0] tnew;
  } wr_t;

  // Source registers and md flags are only consulted while the instruction sits in E,
  // so M and W carry just the write-back part of the slot.
  typedef struct packed {
    wr_t        wr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       is_md;
    logic       is_div;
  } e_slot_t;

  e_slot_t        e_q, e_d;
  wr_t            m_q, m_d, w_q;
  logic [CntW-1:0] md_cnt_q, md_cnt_d;

  logic stall;
  logic busy;

  function automatic logic slot_match(wr_t s, logic [4:0] r);
    return s.valid && s.we && (s.dst == r) && (r != 5'd0);
  endfunction

  function automatic logic hazard(wr_t e, wr_t m, logic [4:0] r, logic tuse);
    return (slot_match(e, r) && (e.tnew > {1'b0, tuse})) ||
           (slot_match(m, r) && (m.tnew > {1'b0, tuse}));
  endfunction

  // The newest matching producer decides; if it is not ready yet the read falls back to
  // the GRF and the stall takes care of it.
  function automatic logic [1:0] fwd_d_sel(wr_t e, wr_t m, wr_t w, logic [4:0] r);
    if (slot_match(e, r)) return (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    if (slot_match(m, r)) return (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    if (slot_match(w, r)) return (w.tnew == 2'd0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_e_sel(wr_t m, wr_t w, logic e_valid, logic [4:0] r);
    if (!e_valid) return 2'd0;
    if (slot_match(m, r) && (m.tnew == 2'd0)) return 2'd1;
    if (slot_match(w, r)) return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    busy  = (md_cnt_q != '0) || (e_q.wr.valid && e_q.is_md);
    stall = (D_rs_used && hazard(e_q.wr, m_q, D_rs, D_Tuse_rs)) ||
            (D_rt_used && hazard(e_q.wr, m_q, D_rt, D_Tuse_rt)) ||
            (D_uses_hilo && busy);
  end

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.wr.valid = 1'b1;
      e_d.wr.we    = D_we;
      e_d.wr.dst   = D_dst;
      e_d.wr.tnew  = D_Tnew;
      e_d.rs       = D_rs;
      e_d.rt       = D_rt;
      e_d.is_md    = D_is_md;
      e_d.is_div   = D_is_div;
    end

    m_d = e_q.wr;
    if (e_q.wr.tnew != 2'd0) m_d.tnew = e_q.wr.tnew - 2'd1;

    md_cnt_d = md_cnt_q;
    if (e_q.wr.valid && e_q.is_md) begin
      md_cnt_d = e_q.is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= m_q;
      md_cnt_q <= md_cnt_d;
    end
  end

  // All outputs are held low while reset is asserted.
  always_comb begin
    stall_F  = reset & stall;
    stall_D  = reset & stall;
    flush_E  = reset & stall;
    md_busy  = reset & busy;
    fwd_D_rs = reset ? fwd_d_sel(e_q.wr, m_q, w_q, D_rs) : 2'd0;
    fwd_D_rt = reset ? fwd_d_sel(e_q.wr, m_q, w_q, D_rt) : 2'd0;
    fwd_E_rs = reset ? fwd_e_sel(m_q, w_q, e_q.wr.valid, e_q.rs) : 2'd0;
    fwd_E_rt = reset ? fwd_e_sel(m_q, w_q, e_q.wr.valid, e_q.rt) : 2'd0;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, jal/jr, $0 writes and mult/div busy windows.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_dst;
  logic       D_rs_used, D_rt_used, D_Tuse_rs, D_Tuse_rt, D_we;
  logic [1:0] D_Tnew;
  logic       D_is_md, D_is_div, D_uses_hilo;
  logic       stall_F, stall_D, flush_E, md_busy;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_used  (D_rs_used),
    .D_rt_used  (D_rt_used),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_we       (D_we),
    .D_dst      (D_dst),
    .D_Tnew     (D_Tnew),
    .D_is_md    (D_is_md),
    .D_is_div   (D_is_div),
    .D_uses_hilo(D_uses_hilo),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_E    (flush_E),
    .fwd_D_rs   (fwd_D_rs),
    .fwd_D_rt   (fwd_D_rt),
    .fwd_E_rs   (fwd_E_rs),
    .fwd_E_rt   (fwd_E_rt),
    .md_busy    (md_busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic rs_used, input logic tuse_rs,
                       input logic [4:0] rt, input logic rt_used, input logic tuse_rt,
                       input logic we, input logic [4:0] dst, input logic [1:0] tnew,
                       input logic is_md, input logic is_div, input logic uses_hilo);
    D_rs = rs; D_rs_used = rs_used; D_Tuse_rs = tuse_rs;
    D_rt = rt; D_rt_used = rt_used; D_Tuse_rt = tuse_rt;
    D_we = we; D_dst = dst; D_Tnew = tnew;
    D_is_md = is_md; D_is_div = is_div; D_uses_hilo = uses_hilo;
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall_F"}, stall_F, 0);
    check({tag, ".stall_D"}, stall_D, 0);
    check({tag, ".flush_E"}, flush_E, 0);
    check({tag, ".fwd_D_rs"}, fwd_D_rs, 0);
    check({tag, ".fwd_E_rs"}, fwd_E_rs, 0);
    check({tag, ".md_busy"}, md_busy, 0);
  endtask

  // Counts cycles the D-stage hilo reader stays stalled, bounded by a cycle budget.
  task automatic count_stall(output int cycles);
    cycles = 0;
    while (stall_F && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    // 1: reset with a reader of $5 in D
    reset = 1'b0;
    set_d(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all_zero("rst1");
    tick();
    check_all_zero("rst2");
    reset = 1'b1;
    #1;
    check("rel.stall", stall_F, 0);
    check("rel.busy", md_busy, 0);

    // 2: lw $5 then addu reading $5 in E
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
    check("lw.stall_F", stall_F, 1);
    check("lw.stall_D", stall_D, 1);
    check("lw.flush_E", flush_E, 1);
    tick();
    check("lw.stall_after", stall_F, 0);
    check("lw.fwd_D_rs", fwd_D_rs, 0);
    tick();
    nop();
    check("lw.fwd_E_rs", fwd_E_rs, 2);
    check("lw.fwd_E_rt", fwd_E_rt, 0);
    tick();

    // 3: addu $3 then beq $3,$6 (addu $6 now in W)
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd3, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("beq.stall", stall_F, 1);
    check("beq.fwd_D_rt_W", fwd_D_rt, 3);
    tick();
    check("beq.stall_after", stall_F, 0);
    check("beq.fwd_D_rs_M", fwd_D_rs, 2);
    check("beq.fwd_D_rt", fwd_D_rt, 0);
    tick();

    // 4: jal then jr $31
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd31, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("jr.stall", stall_F, 0);
    check("jr.fwd_D_rs_E", fwd_D_rs, 1);
    tick();
    check("jr.fwd_E_rs_M", fwd_E_rs, 1);

    // 5: load into $0 then reader of $0
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    set_d(5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("r0.stall", stall_F, 0);
    check("r0.fwd_D_rs", fwd_D_rs, 0);
    check("r0.fwd_D_rt", fwd_D_rt, 0);
    tick();
    nop();
    check("r0.fwd_E_rs", fwd_E_rs, 0);
    check("r0.fwd_E_rt", fwd_E_rt, 0);

    // 6a: div then mfhi
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    check("div.no_stall", stall_F, 0);
    tick();
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    check("div.busy", md_busy, 1);
    count_stall(n);
    check("div.stall_cycles", n, 11);
    check("div.busy_end", md_busy, 0);
    tick();

    // 6b: mult then mfhi
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    check("mult.no_stall", stall_F, 0);
    tick();
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    check("mult.busy", md_busy, 1);
    count_stall(n);
    check("mult.stall_cycles", n, 6);
    tick();

    // Reset in the middle of a div discards the busy window
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    nop();
    tick();
    check("mid.busy", md_busy, 1);
    reset = 1'b0;
    set_d(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("mid.forced_busy", md_busy, 0);
    check("mid.forced_stall", stall_F, 0);
    tick();
    reset = 1'b1;
    #1;
    check("mid.busy_cleared", md_busy, 0);
    check("mid.stall_cleared", stall_F, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
